// File: rtl/alarm_sched.sv
// alarm_sched: fixed-priority buzzer scheduler for three alarm sources.
// jamErr and allFull are level requests; batchDone is a one-shot that plays
// DONE_BEEPS on-beats. The operator can silence a level alarm until its request
// drops, or dismiss a pending done. Music gates the external CLK_1 tone with the
// beat pattern of the granted source.
module alarm_sched #(
    parameter int BEAT_DIV   = 25000000,
    parameter int DONE_BEEPS = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CLK_1,
    input  logic       jamErr,
    input  logic       allFull,
    input  logic       batchDone,
    input  logic       ack,
    output logic       Music,
    output logic [1:0] srcId,
    output logic       busy
);

    localparam int              CW         = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;
    localparam logic [CW-1:0]   BEAT_LAST  = CW'(BEAT_DIV - 1);
    localparam logic [3:0]      BEEPS_LAST = 4'(DONE_BEEPS);

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_JAM  = 2'b01;
    localparam logic [1:0] SRC_FULL = 2'b10;
    localparam logic [1:0] SRC_DONE = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] beatCnt;
    logic          phase;
    logic [3:0]    doneBeeps;
    logic          donePend;
    logic          muteJam;
    logic          muteFull;

    logic          jamElig;
    logic          fullElig;
    logic          doneElig;
    logic [1:0]    grant;
    logic          grantChg;
    logic          beatEnd;
    logic          strobe;
    logic          doneFinish;
    logic          toneOn;

    // Eligibility, fixed-priority arbitration and beat/tone decode from current state
    always_comb begin
        jamElig  = jamErr & ~muteJam;
        fullElig = allFull & ~muteFull;
        doneElig = donePend;

        grant = SRC_NONE;
        if (jamElig)
            grant = SRC_JAM;
        else if (fullElig)
            grant = SRC_FULL;
        else if (doneElig)
            grant = SRC_DONE;

        grantChg = (grant != srcId);
        beatEnd  = (beatCnt == BEAT_LAST);
        // A grant change restarts the beat, so it never also counts as a strobe.
        strobe   = (state == PLAY) && !grantChg && beatEnd;

        // The done sequence ends on the off-beat strobe after the last on-beat.
        doneFinish = strobe && (srcId == SRC_DONE) && phase && (doneBeeps == BEEPS_LAST);

        // The granted source still holds the grant for one edge after being
        // muted, dismissed or completed; gating on those flags keeps that tail
        // cycle silent instead of emitting a one-cycle blip.
        toneOn = 1'b0;
        case (srcId)
            SRC_JAM:  toneOn = ~muteJam;
            SRC_FULL: toneOn = ~phase & ~muteFull;
            SRC_DONE: toneOn = ~phase & donePend;
            default:  toneOn = 1'b0;
        endcase
    end

    // IDLE/PLAY FSM with registered grant outputs and the beat timebase
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            srcId     <= SRC_NONE;
            busy      <= 1'b0;
            Music     <= 1'b0;
            beatCnt   <= '0;
            phase     <= 1'b0;
            doneBeeps <= 4'd0;
        end else begin
            srcId <= grant;
            busy  <= (grant != SRC_NONE);
            Music <= CLK_1 & toneOn;

            case (state)
                IDLE:    if (grant != SRC_NONE) state <= PLAY;
                PLAY:    if (grant == SRC_NONE) state <= IDLE;
                default: state <= IDLE;
            endcase

            if (grantChg) begin
                // New owner (or release) always starts from the top of an on-beat.
                beatCnt   <= '0;
                phase     <= 1'b0;
                doneBeeps <= 4'd0;
            end else if (state == PLAY) begin
                if (beatEnd) begin
                    beatCnt <= '0;
                    phase   <= ~phase;
                    // Only the done sequence needs its on-beats counted.
                    if ((srcId == SRC_DONE) && !phase)
                        doneBeeps <= doneBeeps + 4'd1;
                end else begin
                    beatCnt <= beatCnt + 1'b1;
                end
            end
        end
    end

    // Mute flags and the single-entry done latch
    always_ff @(posedge CLK) begin
        if (RST) begin
            donePend <= 1'b0;
            muteJam  <= 1'b0;
            muteFull <= 1'b0;
        end else begin
            // A dropped request re-arms its alarm; that wins over a same-cycle ack.
            if (!jamErr)
                muteJam <= 1'b0;
            else if (ack && (srcId == SRC_JAM))
                muteJam <= 1'b1;

            if (!allFull)
                muteFull <= 1'b0;
            else if (ack && (srcId == SRC_FULL))
                muteFull <= 1'b1;

            // A fresh pulse beats a same-cycle completion or dismissal.
            if (batchDone)
                donePend <= 1'b1;
            else if ((ack && (srcId == SRC_DONE)) || doneFinish)
                donePend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alarm_sched.sv
// Bench for alarm_sched: directed scenarios followed by a randomized run, all
// checked cycle by cycle against a timeline model (time since grant, beat index
// derived by division) kept here.
module tb_alarm_sched;

    localparam int BD = 4;
    localparam int DB = 3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       CLK_1 = 1'b1;
    logic       jamErr = 1'b0;
    logic       allFull = 1'b0;
    logic       batchDone = 1'b0;
    logic       ack = 1'b0;
    logic       Music;
    logic [1:0] srcId;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference state: who owns the buzzer and how many edges since it took it.
    logic [1:0] mSrc = 2'b00;
    int         mT = 0;
    logic       mPend = 1'b0;
    logic       mMuteJ = 1'b0;
    logic       mMuteF = 1'b0;
    logic       expMusic = 1'b0;

    alarm_sched #(.BEAT_DIV(BD), .DONE_BEEPS(DB)) dut (
        .CLK(CLK), .RST(RST), .CLK_1(CLK_1), .jamErr(jamErr), .allFull(allFull),
        .batchDone(batchDone), .ack(ack), .Music(Music), .srcId(srcId), .busy(busy)
    );

    always #5 CLK = ~CLK;

    // Advance one edge: update the model with the inputs seen at that edge,
    // then compare all outputs 1 time unit later.
    task automatic tick(input string tag);
        logic [1:0] g;
        logic       ph0;
        logic       tone;
        logic       finish;
        @(posedge CLK);
        if (RST) begin
            mPend = 1'b0; mMuteJ = 1'b0; mMuteF = 1'b0;
            mSrc = 2'b00; mT = 0; expMusic = 1'b0;
        end else begin
            if (jamErr && !mMuteJ)       g = 2'b01;
            else if (allFull && !mMuteF) g = 2'b10;
            else if (mPend)              g = 2'b11;
            else                         g = 2'b00;
            ph0 = ((mT / BD) % 2) == 0;
            case (mSrc)
                2'b01:   tone = !mMuteJ;
                2'b10:   tone = ph0 && !mMuteF;
                2'b11:   tone = ph0 && mPend;
                default: tone = 1'b0;
            endcase
            expMusic = CLK_1 && tone;
            // DB on-beats and DB off-beats have fully elapsed at this edge.
            finish = (mSrc == 2'b11) && (g == 2'b11) && (mT == 2 * DB * BD - 1);
            if (!jamErr) mMuteJ = 1'b0;
            else if (ack && mSrc == 2'b01) mMuteJ = 1'b1;
            if (!allFull) mMuteF = 1'b0;
            else if (ack && mSrc == 2'b10) mMuteF = 1'b1;
            if (batchDone) mPend = 1'b1;
            else if ((ack && mSrc == 2'b11) || finish) mPend = 1'b0;
            mT = (g != mSrc || g == 2'b00) ? 0 : mT + 1;
            mSrc = g;
        end
        #1;
        vectors++;
        assert (srcId === mSrc) else begin
            miscompares++;
            $error("FAIL %s srcId got %b want %b at %0t", tag, srcId, mSrc, $time);
        end
        vectors++;
        assert (busy === (mSrc != 2'b00)) else begin
            miscompares++;
            $error("FAIL %s busy got %b want %b at %0t", tag, busy, (mSrc != 2'b00), $time);
        end
        vectors++;
        assert (Music === expMusic) else begin
            miscompares++;
            $error("FAIL %s Music got %b want %b at %0t", tag, Music, expMusic, $time);
        end
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    initial begin
        int  guard;
        logic hit;

        // Reset state
        RST = 1'b1; allFull = 1'b1; jamErr = 1'b1; batchDone = 1'b1;
        run(2, "reset");
        allFull = 1'b0; jamErr = 1'b0; batchDone = 1'b0;
        run(1, "reset");
        RST = 1'b0;
        run(2, "idle");

        // Full alarm pattern, ack mute, drop and re-raise
        allFull = 1'b1;
        run(18, "full_pattern");
        ack = 1'b1; run(1, "full_ack"); ack = 1'b0;
        run(6, "full_muted");
        allFull = 1'b0; run(1, "full_drop");
        allFull = 1'b1; run(12, "full_resume");
        allFull = 1'b0; run(3, "full_off");

        // Jam preempts full mid on-beat, full restarts at phase 0
        allFull = 1'b1; run(4, "pre_full");
        jamErr = 1'b1;  run(5, "jam_preempt");
        jamErr = 1'b0;  run(12, "full_after_jam");
        allFull = 1'b0; run(3, "level_release");

        // Done sequence with an ignored second pulse
        batchDone = 1'b1; run(1, "done_pulse"); batchDone = 1'b0;
        run(10, "done_play");
        batchDone = 1'b1; run(1, "done_repulse"); batchDone = 1'b0;
        run(25, "done_finish");

        // Done preempted by jam, then replayed in full
        batchDone = 1'b1; run(1, "done_pulse2"); batchDone = 1'b0;
        run(3, "done_pre");
        jamErr = 1'b1; run(6, "done_jam");
        jamErr = 1'b0; run(30, "done_resume");

        // Pulse on the exact completion edge re-arms the done
        batchDone = 1'b1; run(1, "done_pulse3"); batchDone = 1'b0;
        hit = 1'b0;
        guard = 0;
        while (!hit && guard < 100) begin
            if (mSrc == 2'b11 && mT == 2 * DB * BD - 1) hit = 1'b1;
            else run(1, "done_seek");
            guard++;
        end
        vectors++;
        assert (hit) else begin
            miscompares++;
            $error("FAIL done_seek completion edge not reached, got %0d edges want <100", guard);
        end
        batchDone = 1'b1; run(1, "done_edge_set"); batchDone = 1'b0;
        run(30, "done_replay");

        // Ack dismisses done; reset mid-play drops a pending done
        batchDone = 1'b1; run(1, "done_pulse4"); batchDone = 1'b0;
        run(5, "done_pre_ack");
        ack = 1'b1; run(1, "done_ack"); ack = 1'b0;
        run(4, "done_dismissed");
        batchDone = 1'b1; run(1, "done_pulse5"); batchDone = 1'b0;
        allFull = 1'b1; run(5, "pre_rst");
        RST = 1'b1; run(1, "rst_mid"); RST = 1'b0;
        run(12, "post_rst");
        allFull = 1'b0; run(3, "post_rst_off");

        // Randomized traffic
        for (int i = 0; i < 2500; i++) begin
            CLK_1     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 29) == 0) jamErr  = ~jamErr;
            if ($urandom_range(0, 19) == 0) allFull = ~allFull;
            batchDone = ($urandom_range(0, 39) == 0);
            ack       = ($urandom_range(0, 24) == 0);
            RST       = ($urandom_range(0, 399) == 0);
            run(1, "random");
        end
        RST = 1'b0; jamErr = 1'b0; allFull = 1'b0; batchDone = 1'b0; ack = 1'b0;
        run(3, "drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
